// File: rtl/vision_pkg.sv
// rtl/vision_pkg.sv - shared window geometry, pixel/window types and feeder states
package vision_pkg;

    localparam int WIN_DIM    = 16;
    localparam int DESC_WORDS = 64;
    localparam int PIX_W      = 8;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t [WIN_DIM-1:0][WIN_DIM-1:0] window_t;

    typedef enum logic [2:0] {
        IDLE,
        DESC_RD,
        DESC_WAIT,
        WIN_LOAD,
        WIN_PRESENT,
        WIN_WAIT,
        FINISH
    } feeder_state_t;

endpackage

// File: rtl/ncc_win_addr_gen.sv
// rtl/ncc_win_addr_gen.sv - incremental window/row address generator for the NCC feeder
module ncc_win_addr_gen
    import vision_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int IMG_W    = 640,
    parameter int SEARCH_W = 16,
    parameter int SEARCH_H = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_i,
    input  logic              next_row_i,
    input  logic              next_window_i,
    input  logic [ADDR_W-1:0] img_base_i,
    output logic [ADDR_W-1:0] row_addr_o,
    output logic [3:0]        row_o,
    output logic [8:0]        win_index_o,
    output logic              last_row_o,
    output logic              last_window_o
);

    localparam logic [ADDR_W-1:0] PITCH = ADDR_W'(IMG_W);

    logic [8:0]        wx_q, wx_d;
    logic [8:0]        wy_q, wy_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] win_base_q, win_base_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    logic [3:0]        row_q, row_d;
    logic [8:0]        idx_q, idx_d;
    logic              last_col;

    assign last_col      = (wx_q == 9'(SEARCH_W - 1));
    assign last_window_o = last_col && (wy_q == 9'(SEARCH_H - 1));
    assign last_row_o    = (row_q == 4'(WIN_DIM - 1));
    assign row_addr_o    = row_addr_q;
    assign row_o         = row_q;
    assign win_index_o   = idx_q;

    // line_base tracks img_base + wy*IMG_W so no multiplier is needed
    always_comb begin
        wx_d        = wx_q;
        wy_d        = wy_q;
        line_base_d = line_base_q;
        win_base_d  = win_base_q;
        row_addr_d  = row_addr_q;
        row_d       = row_q;
        idx_d       = idx_q;
        if (init_i) begin
            wx_d        = '0;
            wy_d        = '0;
            line_base_d = img_base_i;
            win_base_d  = img_base_i;
            row_addr_d  = img_base_i;
            row_d       = '0;
            idx_d       = '0;
        end else if (next_window_i) begin
            row_d = '0;
            idx_d = idx_q + 9'd1;
            if (last_col) begin
                wx_d        = '0;
                wy_d        = wy_q + 9'd1;
                line_base_d = line_base_q + PITCH;
                win_base_d  = line_base_q + PITCH;
                row_addr_d  = line_base_q + PITCH;
            end else begin
                wx_d       = wx_q + 9'd1;
                win_base_d = win_base_q + 1'b1;
                row_addr_d = win_base_q + 1'b1;
            end
        end else if (next_row_i) begin
            row_d      = row_q + 4'd1;
            row_addr_d = row_addr_q + PITCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wx_q        <= '0;
            wy_q        <= '0;
            line_base_q <= '0;
            win_base_q  <= '0;
            row_addr_q  <= '0;
            row_q       <= '0;
            idx_q       <= '0;
        end else begin
            wx_q        <= wx_d;
            wy_q        <= wy_d;
            line_base_q <= line_base_d;
            win_base_q  <= win_base_d;
            row_addr_q  <= row_addr_d;
            row_q       <= row_d;
            idx_q       <= idx_d;
        end
    end

endmodule

// File: rtl/ncc_window_feeder.sv
// rtl/ncc_window_feeder.sv - streams one descriptor then every search window to the NCC core
module ncc_window_feeder
    import vision_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int IMG_W    = 640,
    parameter int SEARCH_W = 16,
    parameter int SEARCH_H = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      desc_base,
    input  logic [ADDR_W-1:0]      img_base,
    output logic                   desc_rd_en,
    output logic [ADDR_W-1:0]      desc_rd_addr,
    input  logic [31:0]            desc_rd_data,
    output logic                   img_rd_en,
    output logic [ADDR_W-1:0]      img_rd_addr,
    input  logic [127:0]           img_rd_data,
    output logic [31:0]            descIn,
    output logic                   desc_data_ready,
    input  logic                   done_with_desc_data,
    output logic [15:0][15:0][7:0] windowIn,
    output logic                   window_data_ready,
    input  logic                   done_with_window_data,
    output logic [8:0]             win_index,
    output logic                   busy,
    output logic                   done
);

    feeder_state_t     state_q;
    logic              desc_rd_en_q;
    logic [ADDR_W-1:0] desc_rd_addr_q;
    logic [5:0]        desc_k_q;
    logic              desc_vld_q;
    logic              desc_data_ready_q;
    logic [31:0]       descIn_q;
    logic              img_rd_en_q;
    logic              cap_en_q;
    logic [3:0]        cap_row_q;
    window_t           windowIn_q;
    logic              window_data_ready_q;
    logic [8:0]        win_index_q;
    logic              done_q;

    logic              ag_init;
    logic              ag_next_row;
    logic              ag_next_window;
    logic [ADDR_W-1:0] ag_row_addr;
    logic [3:0]        ag_row;
    logic [8:0]        ag_index;
    logic              ag_last_row;
    logic              ag_last_window;

    assign ag_init        = (state_q == IDLE) && start;
    assign ag_next_row    = (state_q == WIN_LOAD) && img_rd_en_q;
    assign ag_next_window = (state_q == WIN_WAIT) && done_with_window_data && !ag_last_window;

    ncc_win_addr_gen #(
        .ADDR_W  (ADDR_W),
        .IMG_W   (IMG_W),
        .SEARCH_W(SEARCH_W),
        .SEARCH_H(SEARCH_H)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .init_i       (ag_init),
        .next_row_i   (ag_next_row),
        .next_window_i(ag_next_window),
        .img_base_i   (img_base),
        .row_addr_o   (ag_row_addr),
        .row_o        (ag_row),
        .win_index_o  (ag_index),
        .last_row_o   (ag_last_row),
        .last_window_o(ag_last_window)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q             <= IDLE;
            desc_rd_en_q        <= 1'b0;
            desc_rd_addr_q      <= '0;
            desc_k_q            <= '0;
            desc_vld_q          <= 1'b0;
            desc_data_ready_q   <= 1'b0;
            descIn_q            <= '0;
            img_rd_en_q         <= 1'b0;
            cap_en_q            <= 1'b0;
            cap_row_q           <= '0;
            windowIn_q          <= '0;
            window_data_ready_q <= 1'b0;
            win_index_q         <= '0;
            done_q              <= 1'b0;
        end else begin
            window_data_ready_q <= 1'b0;
            done_q              <= 1'b0;
            // memory returns data one cycle after the strobe; these stages track that latency
            desc_vld_q          <= desc_rd_en_q;
            desc_data_ready_q   <= desc_vld_q;
            if (desc_vld_q) begin
                descIn_q <= desc_rd_data;
            end
            cap_en_q  <= img_rd_en_q;
            cap_row_q <= ag_row;
            if (cap_en_q) begin
                windowIn_q[cap_row_q] <= img_rd_data;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q        <= DESC_RD;
                        desc_rd_en_q   <= 1'b1;
                        desc_rd_addr_q <= desc_base;
                        desc_k_q       <= '0;
                    end
                end
                DESC_RD: begin
                    if (desc_rd_en_q) begin
                        if (desc_k_q == 6'(DESC_WORDS - 1)) begin
                            desc_rd_en_q <= 1'b0;
                        end else begin
                            desc_k_q       <= desc_k_q + 6'd1;
                            desc_rd_addr_q <= desc_rd_addr_q + 1'b1;
                        end
                    end else if (!desc_vld_q && desc_data_ready_q) begin
                        state_q <= DESC_WAIT;
                    end
                end
                DESC_WAIT: begin
                    if (done_with_desc_data) begin
                        state_q     <= WIN_LOAD;
                        img_rd_en_q <= 1'b1;
                    end
                end
                WIN_LOAD: begin
                    if (img_rd_en_q && ag_last_row) begin
                        img_rd_en_q <= 1'b0;
                    end
                    if (cap_en_q && (cap_row_q == 4'(WIN_DIM - 1))) begin
                        state_q             <= WIN_PRESENT;
                        window_data_ready_q <= 1'b1;
                        win_index_q         <= ag_index;
                    end
                end
                WIN_PRESENT: begin
                    state_q <= WIN_WAIT;
                end
                WIN_WAIT: begin
                    if (done_with_window_data) begin
                        if (ag_last_window) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= WIN_LOAD;
                            img_rd_en_q <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign desc_rd_en        = desc_rd_en_q;
    assign desc_rd_addr      = desc_rd_addr_q;
    assign img_rd_en         = img_rd_en_q;
    assign img_rd_addr       = ag_row_addr;
    assign descIn            = descIn_q;
    assign desc_data_ready   = desc_data_ready_q;
    assign windowIn          = windowIn_q;
    assign window_data_ready = window_data_ready_q;
    assign win_index         = win_index_q;
    assign busy              = (state_q != IDLE);
    assign done              = done_q;

endmodule
